seg7_mux_scan: RTL
==================

Name: seg7_mux_scan

Overview:
- Parametrised N-digit seven-segment scan driver. Successor to the fixed 4-digit anode/segment multiplexer.
- Time-multiplexes N_DIGITS 4-bit character codes onto one shared segment bus plus per-digit anodes.
- Adds the following:
  - frame-synchronous input latching, so there is no tearing;
  - inter-digit dead time for ghost suppression;
  - per-digit enable mask;
  - PWM brightness;
  - optional leading-zero blanking;
  - configurable output polarity.

Parameters:
- N_DIGITS, 4: number of digits, legal range 1..8.
- DIV, 250: clocks per digit slot, must be >= 2.
- DEAD, 4: clocks at the start of each slot with all anodes off. Must satisfy 0 <= DEAD < DIV.
- AN_ACTIVE_LOW, 1: 1 means an selected = 0.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment/dp = 0.
- LZB, 0: 1 enables leading-zero blanking.
- BW, $clog2(DIV-DEAD+1): width of the brightness input.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- chars  in  4*N_DIGITS  character codes; digit i = chars[4i+3:4i]; digit 0 is rightmost.
- dp_in  in  N_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  N_DIGITS  per-digit enable, 1 = shown.
- brightness  in  BW  anode on-time per slot in clocks.
- display  out  7  segments {a,b,c,d,e,f,g}, polarity set by SEG_ACTIVE_LOW.
- dp  out  1  decimal point, polarity set by SEG_ACTIVE_LOW.
- an  out  N_DIGITS  anodes, polarity set by AN_ACTIVE_LOW.
- frame_start  out  1  one-clock pulse marking the edge at which the shadow registers load.

Behaviour:
- Reset, asynchronous, takes effect immediately including mid-frame:
  - cyc = 0, slot = 0, frame_start = 0;
  - shadow chars = 12 (blank), shadow dp = 0, shadow en = 0;
  - an/display/dp driven to their inactive levels.
- Counters:
  - cyc runs 0..DIV-1.
  - On cyc == DIV-1, cyc wraps to 0 and slot increments, wrapping N_DIGITS-1 -> 0.
  - Frame period = N_DIGITS*DIV clocks, constant regardless of enables or brightness.
- Shadow load:
  - Occurs on the edge where slot == N_DIGITS-1 and cyc == DIV-1.
  - chars, dp_in and digit_en are captured into the shadow registers; frame_start is 1 for the following clock.
  - The first frame after reset is therefore fully dark.
  - Input changes mid-frame have no visible effect until the next frame.
  - brightness is not shadowed; it is sampled live every clock.
- Character decode, in active-high form before the polarity inversion:
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
  - 10 '-': 0000001
  - 11 'F': 1000111
  - 12..15: blank (0000000)
- Leading-zero blanking (LZB = 1):
  - Scanning from digit N_DIGITS-1 downward, each code 0 or 12..15 is treated as blank until the first code in 1..11.
  - Digit 0 is never blanked by this rule; its code 0 still shows '0'.
  - LZB = 0 disables the rule.
- Anode active for digit = slot when all of the following hold:
  - DEAD <= cyc;
  - (cyc - DEAD) < min(brightness, DIV-DEAD);
  - shadow en[slot] = 1.
- All other anodes are inactive at all times.
- brightness = 0 means the display is dark; values above DIV-DEAD saturate to DIV-DEAD.
- Segment bus:
  - display/dp carry the decode of shadow digit [slot] throughout the whole slot, dead time included.
  - When the anode is inactive because of an enable of 0, the segments show blank.
- Output timing:
  - an, display and dp are registered and are a function of (slot, cyc, shadow) before the edge. Result: one-clock latency relative to the counters.
  - This keeps all outputs glitch-free.
- Simultaneous events:
  - A shadow load and a slot wrap coincide by construction.
  - A reset assertion overrides everything.

Test Plan:
1. Parameters N_DIGITS=4, DIV=8, DEAD=2, brightness=6; assert reset mid-frame -> an=1111, display=1111111, dp=1 with no clock edge; frame_start=0.
2. chars=16'hA194, digit_en=4'hF, dp_in=0 -> frame 1 is all dark. From frame 2 onward:
   - slot 0: an=1110 for the clocks at cyc 3..8 (lag-shifted), display=1001100;
   - slot 1: display=0000100;
   - slot 2: display=1001111;
   - slot 3: display=1111110;
   - frame_start pulses every 32 clocks.
3. brightness=3 -> each anode is low for exactly 3 clocks per 8-clock slot. brightness=0 -> an stays 1111. brightness=15 -> behaves exactly like 6.
4. Change chars from 16'hA194 to 16'hBBBB during slot 1 -> display unchanged until the next frame_start, then every digit shows 0111000 ('F').
5. LZB=1 and the following chars values:
   - 16'h0007 -> slots 3..1 blank (1111111), slot 0 shows 0001111;
   - 16'h0000 -> only digit 0 lit, showing 0000001;
   - 16'hC010 -> digits 3 and 2 blank.
6. digit_en=4'b0101 -> an never asserts in slots 1 or 3, and display is blank during those slots. Slot timing and the frame_start period stay at 32 clocks.

Source files
------------

// File: rtl/seg7_mux_scan_if.sv
// Bundle between a character source and the seven-segment scan driver.
// The source side drives characters and controls; the driver side returns pins.
interface seg7_mux_scan_if #(
    parameter int N_DIGITS = 4,
    parameter int BW       = 8
);
    logic [4*N_DIGITS-1:0] chars;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic [BW-1:0]         brightness;
    logic [6:0]            display;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_start;

    modport master (
        output chars, dp_in, digit_en, brightness,
        input  display, dp, an, frame_start
    );

    modport slave (
        input  chars, dp_in, digit_en, brightness,
        output display, dp, an, frame_start
    );
endinterface

// File: rtl/seg7_mux_scan.sv
// N-digit seven-segment scan driver with frame-synchronous shadowing,
// dead time, per-digit enables, PWM brightness and leading-zero blanking.
module seg7_mux_scan #(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 250,
    parameter int DEAD           = 4,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int LZB            = 0,
    parameter int BW             = $clog2(DIV - DEAD + 1)
) (
    input logic           clk,
    input logic           reset,
    seg7_mux_scan_if.slave bus
);
    localparam int CW   = $clog2(DIV);
    localparam int SW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SPAN = DIV - DEAD;

    localparam logic [CW-1:0] CYC_MAX  = CW'(DIV - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(N_DIGITS - 1);
    localparam logic          AN_INV   = (AN_ACTIVE_LOW != 0);
    localparam logic          SEG_INV  = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{AN_INV}};

    logic [CW-1:0]         cyc;
    logic [SW-1:0]         slot;
    logic [4*N_DIGITS-1:0] sh_chars;
    logic [N_DIGITS-1:0]   sh_dp;
    logic [N_DIGITS-1:0]   sh_en;
    logic                  frame_start_q;
    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            disp_q;
    logic                  dp_q;

    logic                  slot_end;
    logic                  load;
    logic [N_DIGITS-1:0]   lz_blank;
    logic                  lead_zone;
    logic [3:0]            code;
    logic [6:0]            seg;
    logic                  lit;
    logic                  dp_lit;
    logic [31:0]           rel;
    logic [31:0]           lim;
    logic [N_DIGITS-1:0]   an_next;

    assign slot_end = (cyc == CYC_MAX);
    assign load     = slot_end && (slot == SLOT_MAX);

    // Blank from the top digit down until the first real glyph; digit 0 always shows.
    always_comb begin
        lz_blank  = '0;
        lead_zone = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            if (sh_chars[4*i +: 4] inside {[4'd1:4'd11]})
                lead_zone = 1'b0;
            if (LZB != 0 && i != 0 && lead_zone)
                lz_blank[i] = 1'b1;
        end
    end

    always_comb begin
        code = 4'd12;
        if (sh_en[slot] && !lz_blank[slot])
            code = sh_chars[{slot, 2'b00} +: 4];
    end

    always_comb begin
        case (code)
            4'd0:    seg = 7'b1111110;
            4'd1:    seg = 7'b0110000;
            4'd2:    seg = 7'b1101101;
            4'd3:    seg = 7'b1111001;
            4'd4:    seg = 7'b0110011;
            4'd5:    seg = 7'b1011011;
            4'd6:    seg = 7'b1011111;
            4'd7:    seg = 7'b1110000;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1111011;
            4'd10:   seg = 7'b0000001;
            4'd11:   seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end

    // On-window after the dead time, clamped to the usable part of the slot.
    always_comb begin
        rel = 32'(cyc) - 32'(DEAD);
        lim = (32'(bus.brightness) > 32'(SPAN)) ? 32'(SPAN)
                                                : 32'(bus.brightness);
        lit = (32'(cyc) >= 32'(DEAD)) && (rel < lim) && sh_en[slot];
        an_next = lit ? (N_DIGITS'(1) << slot) : '0;
        dp_lit  = sh_dp[slot] && sh_en[slot];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc           <= '0;
            slot          <= '0;
            frame_start_q <= 1'b0;
            sh_chars      <= {N_DIGITS{4'hC}};
            sh_dp         <= '0;
            sh_en         <= '0;
            an_q          <= AN_OFF;
            disp_q        <= {7{SEG_INV}};
            dp_q          <= SEG_INV;
        end else begin
            if (slot_end) begin
                cyc  <= '0;
                slot <= (slot == SLOT_MAX) ? '0 : slot + SW'(1);
            end else begin
                cyc <= cyc + CW'(1);
            end
            frame_start_q <= load;
            if (load) begin
                sh_chars <= bus.chars;
                sh_dp    <= bus.dp_in;
                sh_en    <= bus.digit_en;
            end
            an_q   <= an_next ^ AN_OFF;
            disp_q <= seg ^ {7{SEG_INV}};
            dp_q   <= dp_lit ^ SEG_INV;
        end
    end

    assign bus.an          = an_q;
    assign bus.display     = disp_q;
    assign bus.dp          = dp_q;
    assign bus.frame_start = frame_start_q;
endmodule
